keypad_entry: RTL and testbench

Parametrised matrix-keypad scanner with debounce and a multi-digit entry buffer, replacing the fixed 4x4, six-slot password scanner in the safe-box front end. It drives active-low columns, decodes one key per press, and assembles digits into an ordered buffer. The buffer supports clear, backspace and enter keys, and hands a completed entry to the password comparator with a one-cycle `entry_done` pulse.

---
 rtl/keypad_entry.sv | 264 ++++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Brief    : Matrix-keypad scanner with tick-based debounce and an ordered
//            multi-digit entry buffer (clear / backspace / enter keys).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module keypad_entry #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SCAN_DIV  = 32768,
    parameter int DEBOUNCE  = 2,
    parameter int DIGITS    = 6,
    parameter int KEY_ENTER = 14,
    parameter int KEY_CLEAR = 15,
    parameter int KEY_BACK  = 12,
    localparam int KN = ROWS * COLS,
    localparam int KW = $clog2(KN),
    localparam int EW = $clog2(KN + 1),
    localparam int CW = $clog2(DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [ROWS-1:0]      row_in,
    output logic [COLS-1:0]      col_out,
    output logic                 key_valid,
    output logic [KW-1:0]        key_code,
    output logic [DIGITS*EW-1:0] digits,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 overflow,
    output logic                 entry_done
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW  = $clog2(DEBOUNCE + 1);
    localparam logic [EW-1:0] C_EMPTY = EW'(KN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_PRESSED = 2'd3
    } state_t;

    // Active-low drive pattern selecting a single column.
    function automatic logic [COLS-1:0] col_drive(input logic [CIW-1:0] k);
        return ~(COLS'(1) << k);
    endfunction

    logic [DW-1:0]   r_div;
    logic            w_tick;
    state_t          r_state,     w_state_nxt;
    logic [CIW-1:0]  r_k,         w_k_nxt;
    logic [RIW-1:0]  r_row,       w_row_nxt;
    logic [SW-1:0]   r_stab,      w_stab_nxt;
    logic [COLS-1:0] r_col_out,   w_col_out_nxt;
    logic            r_key_valid, w_key_valid_nxt;
    logic [KW-1:0]   r_key_code,  w_key_code_nxt;
    logic            w_any_low;
    logic [RIW-1:0]  w_low_idx;

    logic [EW-1:0]   r_slot [DIGITS];
    logic [CW-1:0]   r_count;
    logic            r_done;
    logic            r_entry_done;
    logic            r_overflow;
    logic [EW-1:0]   w_digit;

    assign w_tick    = (r_div == DW'(SCAN_DIV - 1));
    assign w_any_low = ~&row_in;
    assign w_digit   = EW'(r_key_code);

    // Free-running scan divider; clr deliberately leaves it running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + DW'(1);
    end

    // Priority encode the lowest active (low) row.
    always_comb begin
        w_low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_in[i])
                w_low_idx = RIW'(i);
        end
    end

    // Scanner state register; column drive and key strobe are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_row       <= '0;
            r_stab      <= '0;
            r_col_out   <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_row       <= w_row_nxt;
            r_stab      <= w_stab_nxt;
            r_col_out   <= w_col_out_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_code  <= w_key_code_nxt;
        end
    end

    // Scanner next-state: every transition is gated by the scan tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_row_nxt       = r_row;
        w_stab_nxt      = r_stab;
        w_col_out_nxt   = r_col_out;
        w_key_valid_nxt = 1'b0;
        w_key_code_nxt  = r_key_code;
        if (clr) begin
            w_state_nxt    = ST_IDLE;
            w_k_nxt        = '0;
            w_row_nxt      = '0;
            w_stab_nxt     = '0;
            w_col_out_nxt  = '0;
            w_key_code_nxt = '0;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_col_out_nxt = '0;
                    if (w_any_low) begin
                        w_state_nxt   = ST_SCAN;
                        w_k_nxt       = '0;
                        w_col_out_nxt = col_drive('0);
                    end
                end
                ST_SCAN: begin
                    if (w_any_low) begin
                        w_row_nxt  = w_low_idx;
                        w_stab_nxt = SW'(1);
                        if (DEBOUNCE == 1) begin
                            // Single-tick debounce: the scan hit itself is the confirmation.
                            w_state_nxt     = ST_PRESSED;
                            w_stab_nxt      = '0;
                            w_key_valid_nxt = 1'b1;
                            w_key_code_nxt  = KW'(int'(w_low_idx) * COLS + int'(r_k));
                        end else begin
                            w_state_nxt = ST_CONFIRM;
                        end
                    end else if (r_k == CIW'(COLS - 1)) begin
                        w_state_nxt   = ST_IDLE;
                        w_col_out_nxt = '0;
                    end else begin
                        w_k_nxt       = r_k + CIW'(1);
                        w_col_out_nxt = col_drive(r_k + CIW'(1));
                    end
                end
                ST_CONFIRM: begin
                    if (!row_in[r_row]) begin
                        if (r_stab + SW'(1) == SW'(DEBOUNCE)) begin
                            w_state_nxt     = ST_PRESSED;
                            w_stab_nxt      = '0;
                            w_key_valid_nxt = 1'b1;
                            w_key_code_nxt  = KW'(int'(r_row) * COLS + int'(r_k));
                        end else begin
                            w_stab_nxt = r_stab + SW'(1);
                        end
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_col_out_nxt = '0;
                    end
                end
                default: begin
                    // Pressed: hold the column, wait for a stable release.
                    if (w_any_low) begin
                        w_stab_nxt = '0;
                    end else if (r_stab + SW'(1) == SW'(DEBOUNCE)) begin
                        w_state_nxt   = ST_IDLE;
                        w_stab_nxt    = '0;
                        w_col_out_nxt = '0;
                    end else begin
                        w_stab_nxt = r_stab + SW'(1);
                    end
                end
            endcase
        end
    end

    // Entry buffer: consumes each key strobe one clock after it appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++)
                r_slot[i] <= C_EMPTY;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_entry_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_entry_done <= 1'b0;
            r_overflow   <= 1'b0;
            if (clr) begin
                for (int i = 0; i < DIGITS; i++)
                    r_slot[i] <= C_EMPTY;
                r_count <= '0;
                r_done  <= 1'b0;
            end else if (r_key_valid) begin
                if (r_key_code == KW'(KEY_CLEAR)) begin
                    for (int i = 0; i < DIGITS; i++)
                        r_slot[i] <= C_EMPTY;
                    r_count <= '0;
                    r_done  <= 1'b0;
                end else if (r_key_code == KW'(KEY_BACK)) begin
                    if (r_count != '0) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (CW'(i + 1) == r_count)
                                r_slot[i] <= C_EMPTY;
                        end
                        r_count <= r_count - CW'(1);
                    end
                    r_done <= 1'b0;
                end else if (r_key_code == KW'(KEY_ENTER)) begin
                    r_entry_done <= 1'b1;
                    r_done       <= 1'b1;
                end else if (r_done) begin
                    // First digit after a completed entry starts a fresh one.
                    for (int i = 0; i < DIGITS; i++)
                        r_slot[i] <= (i == 0) ? w_digit : C_EMPTY;
                    r_count <= CW'(1);
                    r_done  <= 1'b0;
                end else if (r_count != CW'(DIGITS)) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (CW'(i) == r_count)
                            r_slot[i] <= w_digit;
                    end
                    r_count <= r_count + CW'(1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_slot
            assign digits[g*EW +: EW] = r_slot[g];
        end
    endgenerate

    assign col_out    = r_col_out;
    assign key_valid  = r_key_valid;
    assign key_code   = r_key_code;
    assign count      = r_count;
    assign full       = (r_count == CW'(DIGITS));
    assign overflow   = r_overflow;
    assign entry_done = r_entry_done;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Brief    : Directed self-checking bench for keypad_entry with a behavioural
//            4x4 keypad (row pulled low when its key is down and its column
//            is driven low).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DIGITS = 6;
    localparam int KN     = 16;
    localparam int KW     = 4;
    localparam int EW     = 5;
    localparam int CW     = 3;
    localparam int EMPTY  = 16;

    logic                 clk;
    logic                 rst;
    logic                 clr;
    logic [ROWS-1:0]      row_in;
    logic [COLS-1:0]      col_out;
    logic                 key_valid;
    logic [KW-1:0]        key_code;
    logic [DIGITS*EW-1:0] digits;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 overflow;
    logic                 entry_done;

    logic [KN-1:0] keys;
    int            n_checks  = 0;
    int            n_errors  = 0;
    int            kv_cnt    = 0;
    int            ovf_cnt   = 0;
    int            done_cnt  = 0;
    logic [KW-1:0] last_code = '0;

    keypad_entry #(
        .SCAN_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .digits     (digits),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .entry_done (entry_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_in = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS + c] && !col_out[c])
                    row_in[r] = 1'b0;
    end

    // Pulse counters for strobe outputs.
    always @(posedge clk) begin
        if (key_valid) begin
            kv_cnt    <= kv_cnt + 1;
            last_code <= key_code;
        end
        if (overflow)
            ovf_cnt <= ovf_cnt + 1;
        if (entry_done)
            done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DIGITS*EW-1:0] pack(input int s0, input int s1, input int s2,
                                                  input int s3, input int s4, input int s5);
        int v[6];
        logic [DIGITS*EW-1:0] r;
        v = '{s0, s1, s2, s3, s4, s5};
        r = '0;
        for (int i = 0; i < 6; i++)
            r[i*EW +: EW] = EW'(v[i]);
        return r;
    endfunction

    // Hold one key long enough to be accepted, then release and let the scanner settle.
    task automatic press(input int code);
        @(negedge clk);
        keys       = '0;
        keys[code] = 1'b1;
        repeat (60) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
    endtask

    logic [DIGITS*EW-1:0] all_empty;
    int kv0, ovf0, done0, seen;

    initial begin
        all_empty = pack(EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY);
        rst  = 1'b0;
        clr  = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        check("rst_col_out",   col_out,    0);
        check("rst_key_valid", key_valid,  0);
        check("rst_key_code",  key_code,   0);
        check("rst_count",     count,      0);
        check("rst_full",      full,       0);
        check("rst_digits",    digits,     all_empty);
        check("rst_done",      entry_done, 0);
        check("rst_ovf",       overflow,   0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Decode row 2 / col 1
        kv0 = kv_cnt;
        press(9);
        check("dec_kv_pulses", kv_cnt - kv0, 1);
        check("dec_code",      last_code,    9);
        check("dec_digits",    digits,       pack(9, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY));
        check("dec_count",     count,        1);
        press(15);
        check("clr_key_digits", digits, all_empty);
        check("clr_key_count",  count,  0);

        // Glitch: low for exactly two ticks (IDLE sample + SCAN sample), gone by CONFIRM
        kv0 = kv_cnt;
        @(negedge clk);
        keys[0] = 1'b1;
        repeat (8) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        check("glitch_kv",     kv_cnt - kv0, 0);
        check("glitch_count",  count,        0);
        check("glitch_idle",   col_out,      0);
        check("glitch_digits", digits,       all_empty);

        // Fill and overflow
        for (int d = 1; d <= 6; d++)
            press(d);
        check("fill_full",   full,   1);
        check("fill_count",  count,  6);
        check("fill_digits", digits, pack(1, 2, 3, 4, 5, 6));
        ovf0 = ovf_cnt;
        press(7);
        check("ovf_pulses", ovf_cnt - ovf0, 1);
        check("ovf_digits", digits,         pack(1, 2, 3, 4, 5, 6));
        check("ovf_count",  count,          6);
        press(15);

        // Backspace and clear
        press(3);
        press(5);
        press(12);
        check("back_count",  count,  1);
        check("back_digits", digits, pack(3, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY));
        press(12);
        press(12);
        check("back_under_count",  count,  0);
        check("back_under_digits", digits, all_empty);
        press(8);
        check("digit8_count", count, 1);
        press(15);
        check("clear_digits", digits, all_empty);
        check("clear_count",  count,  0);

        // Enter then restart
        done0 = done_cnt;
        press(4);
        press(2);
        press(14);
        check("enter_pulses", done_cnt - done0, 1);
        check("enter_digits", digits, pack(4, 2, EMPTY, EMPTY, EMPTY, EMPTY));
        check("enter_count",  count,  2);
        press(7);
        check("restart_digits", digits, pack(7, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY));
        check("restart_count",  count,  1);
        check("restart_done",   done_cnt - done0, 1);

        // Reset while the press sits in CONFIRM
        kv0 = kv_cnt;
        @(negedge clk);
        keys[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_out == 4'b1110) begin
                seen = 1;
                break;
            end
        end
        check("mrst_scan_seen", seen, 1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_col_out",   col_out,   0);
        check("mrst_key_valid", key_valid, 0);
        keys = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("mrst_kv",     kv_cnt - kv0, 0);
        check("mrst_count",  count,        0);
        check("mrst_digits", digits,       all_empty);

        // clr coincident with key_valid
        @(negedge clk);
        keys[5] = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_valid) begin
                clr  = 1'b1;
                keys = '0;
                seen = 1;
                break;
            end
        end
        check("sclr_kv_seen", seen, 1);
        @(negedge clk);
        clr = 1'b0;
        check("sclr_count_now", count,   0);
        check("sclr_col_out",   col_out, 0);
        repeat (40) @(negedge clk);
        check("sclr_count",  count,  0);
        check("sclr_digits", digits, all_empty);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
